// File: rtl/fabric_config_chain.sv
// Fabric-side endpoint of the FCB serial configuration link.
// prog_clk and fpga_head are sampled on clk, and the shift data goes into a
// CHAIN_LEN-bit config chain. Each completed 32-bit word is added to a
// running checksum. The chain is copied into the shadow config_bits once a
// full chain has been loaded.
module fabric_config_chain #(
  parameter int CHAIN_LEN   = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 prog_en,
  input  logic                 prog_clk,
  input  logic                 fpga_head,
  output logic                 fpga_tail,
  output logic [CHAIN_LEN-1:0] config_bits,
  output logic                 config_valid,
  output logic                 word_strobe,
  output logic [31:0]          bit_count,
  output logic [31:0]          checksum,
  output logic                 load_abort
);

  localparam logic [31:0] LAST_COUNT = 32'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOADED} state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] pclk_sync_reg;
  logic [SYNC_STAGES-1:0] head_sync_reg;
  logic                   pclk_prev_reg;
  logic                   prog_en_prev_reg;
  logic [CHAIN_LEN-1:0]   chain_reg;
  logic [30:0]            word_reg;

  logic                 pclk_s;
  logic                 head_s;
  logic                 shift_evt;
  logic [CHAIN_LEN-1:0] chain_shifted;
  logic [31:0]          word_shifted;
  logic                 load_start;
  logic                 final_evt;
  logic                 load_shift;
  logic                 readback_shift;
  logic                 commit;
  logic                 abort;
  logic                 word_done;

  assign pclk_s        = pclk_sync_reg[SYNC_STAGES-1];
  assign head_s        = head_sync_reg[SYNC_STAGES-1];
  assign shift_evt     = pclk_s & ~pclk_prev_reg;
  assign chain_shifted = {chain_reg[CHAIN_LEN-2:0], head_s};
  // The first bit of a word ends up in bit 31 of the word.
  assign word_shifted  = {word_reg, head_s};
  assign fpga_tail     = chain_reg[CHAIN_LEN-1];

  // Synchronizers for the FCB serial pins, plus edge-detect history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pclk_sync_reg    <= '0;
      head_sync_reg    <= '0;
      pclk_prev_reg    <= 1'b0;
      prog_en_prev_reg <= 1'b0;
    end else begin
      pclk_sync_reg    <= {pclk_sync_reg[SYNC_STAGES-2:0], prog_clk};
      head_sync_reg    <= {head_sync_reg[SYNC_STAGES-2:0], fpga_head};
      pclk_prev_reg    <= pclk_s;
      prog_en_prev_reg <= prog_en;
    end
  end

  // Load FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and per-cycle action decode.
  // A final shift wins over a falling prog_en, so that load still commits.
  always_comb begin
    state_next     = state_reg;
    load_start     = 1'b0;
    final_evt      = 1'b0;
    load_shift     = 1'b0;
    readback_shift = 1'b0;
    commit         = 1'b0;
    abort          = 1'b0;
    word_done      = 1'b0;
    case (state_reg)
      IDLE: begin
        load_start = prog_en & ~prog_en_prev_reg;
        if (load_start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        final_evt  = shift_evt && (bit_count == LAST_COUNT);
        load_shift = shift_evt && (prog_en || final_evt);
        commit     = final_evt;
        abort      = !prog_en && !final_evt;
        word_done  = load_shift && (bit_count[4:0] == 5'd31);
        if (commit) begin
          state_next = LOADED;
        end else if (abort) begin
          state_next = IDLE;
        end
      end
      LOADED: begin
        readback_shift = shift_evt;
        if (!prog_en) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Chain, counters, checksum and shadow config updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain_reg    <= '0;
      word_reg     <= '0;
      config_bits  <= '0;
      config_valid <= 1'b0;
      word_strobe  <= 1'b0;
      bit_count    <= '0;
      checksum     <= '0;
      load_abort   <= 1'b0;
    end else begin
      word_strobe <= word_done;
      if (load_start) begin
        bit_count  <= '0;
        checksum   <= '0;
        load_abort <= 1'b0;
        word_reg   <= '0;
      end
      if (load_shift || readback_shift) begin
        chain_reg <= chain_shifted;
      end
      if (load_shift) begin
        bit_count <= bit_count + 32'd1;
        word_reg  <= word_shifted[30:0];
      end
      if (word_done) begin
        checksum <= checksum + word_shifted;
      end
      if (readback_shift && (bit_count != 32'hFFFF_FFFF)) begin
        bit_count <= bit_count + 32'd1;
      end
      if (commit) begin
        config_bits  <= chain_shifted;
        config_valid <= 1'b1;
      end
      if (abort) begin
        load_abort <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fabric_config_chain.sv
// Testbench for fabric_config_chain with CHAIN_LEN=64 and SYNC_STAGES=2.
// It applies a table of load vectors, then hand-written corner sequences,
// then random loads checked against a bit-history reference model.
module tb_fabric_config_chain;
  localparam int CL = 64;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          prog_en = 1'b0;
  logic          prog_clk = 1'b0;
  logic          fpga_head = 1'b0;
  logic          fpga_tail;
  logic [CL-1:0] config_bits;
  logic          config_valid;
  logic          word_strobe;
  logic [31:0]   bit_count;
  logic [31:0]   checksum;
  logic          load_abort;

  fabric_config_chain #(.CHAIN_LEN(CL), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .prog_en(prog_en), .prog_clk(prog_clk),
    .fpga_head(fpga_head), .fpga_tail(fpga_tail), .config_bits(config_bits),
    .config_valid(config_valid), .word_strobe(word_strobe), .bit_count(bit_count),
    .checksum(checksum), .load_abort(load_abort)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int act_strobes = 0;
  int exp_strobes = 0;

  // Count strobe pulses mid-cycle; a stuck strobe counts once per cycle.
  always @(negedge clk) if (word_strobe === 1'b1) act_strobes++;

  // Reference model: the history of every bit accepted into the chain, plus
  // the bits of the load in progress. Outputs are derived arithmetically.
  bit          m_hist[$];
  bit          m_load[$];
  logic [63:0] m_cfg;
  logic        m_valid;
  logic        m_abort;
  logic [31:0] m_count;
  logic [31:0] m_cksum;
  bit          m_in_load;
  bit          m_full;

  task automatic m_reset();
    m_hist.delete(); m_load.delete();
    m_cfg = '0; m_valid = 1'b0; m_abort = 1'b0; m_count = '0; m_cksum = '0;
    m_in_load = 1'b0; m_full = 1'b0;
  endtask

  task automatic m_start();
    m_load.delete();
    m_count = '0; m_cksum = '0; m_abort = 1'b0;
    m_in_load = 1'b1; m_full = 1'b0;
  endtask

  task automatic m_drop();
    if (m_in_load && !m_full) m_abort = 1'b1;
    m_in_load = 1'b0;
  endtask

  task automatic m_bit(input bit b);
    logic [31:0] w;
    logic [63:0] c;
    int s;
    if (!m_in_load) return;
    m_hist.push_back(b);
    if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    if (!m_full) begin
      m_load.push_back(b);
      if (m_load.size() % 32 == 0) begin
        w = '0;
        s = m_load.size() - 32;
        for (int i = 0; i < 32; i++) w = w * 2 + 32'(m_load[s + i]);
        m_cksum = m_cksum + w;
        exp_strobes++;
      end
      if (m_load.size() == CL) begin
        c = '0;
        for (int i = 0; i < CL; i++) c = c * 2 + 64'(m_load[i]);
        m_cfg = c; m_valid = 1'b1; m_full = 1'b1;
      end
    end
  endtask

  function automatic logic m_tail();
    if (m_hist.size() >= CL) return m_hist[m_hist.size() - CL];
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".cfg"},   config_bits,  m_cfg);
    chk({tag, ".valid"}, 64'(config_valid), 64'(m_valid));
    chk({tag, ".count"}, 64'(bit_count),    64'(m_count));
    chk({tag, ".cksum"}, 64'(checksum),     64'(m_cksum));
    chk({tag, ".abort"}, 64'(load_abort),   64'(m_abort));
    chk({tag, ".tail"},  64'(fpga_tail),    64'(m_tail()));
    chk({tag, ".strobes"}, 64'(act_strobes), 64'(exp_strobes));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit b, input int hi, input int lo);
    fpga_head = b; prog_clk = 1'b1; tick(hi);
    prog_clk = 1'b0; tick(lo);
    m_bit(b);
  endtask

  task automatic start_load();
    prog_en = 1'b1; tick(2); m_start();
  endtask

  task automatic drop_load();
    prog_en = 1'b0; tick(2); m_drop();
  endtask

  task automatic send(input logic [63:0] v, input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) pulse(v[63 - i], hi, lo);
  endtask

  typedef struct {
    logic [63:0] data;
    int          nbits;
    logic [63:0] e_cfg;
    logic        e_valid;
    logic [31:0] e_count;
    logic [31:0] e_cksum;
    logic        e_abort;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] v;
    tbl[0] = '{64'hDEADBEEF_01234567, 64, 64'hDEADBEEF_01234567, 1'b1, 32'd64, 32'hDFD10456, 1'b0};
    tbl[1] = '{64'h01234567_89ABCDEF, 40, 64'hDEADBEEF_01234567, 1'b1, 32'd40, 32'h01234567, 1'b1};
    tbl[2] = '{64'hFFFFFFFF_FFFFFFFF, 64, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 32'd64, 32'hFFFFFFFE, 1'b0};
    tbl[3] = '{64'h80000000_80000000, 64, 64'h80000000_80000000, 1'b1, 32'd64, 32'h00000000, 1'b0};
    tbl[4] = '{64'h00000001_00000002, 0,  64'h80000000_80000000, 1'b1, 32'd0,  32'h00000000, 1'b1};
    tbl[5] = '{64'h00000001_00000002, 64, 64'h00000001_00000002, 1'b1, 32'd64, 32'h00000003, 1'b0};
    tbl[6] = '{64'hFFFFFFFF_00000000, 32, 64'h00000001_00000002, 1'b1, 32'd32, 32'hFFFFFFFF, 1'b1};

    m_reset();
    tick(3);
    chk("rst.cfg", config_bits, 64'd0);
    chk("rst.valid", 64'(config_valid), 64'd0);
    chk("rst.count", 64'(bit_count), 64'd0);
    chk("rst.cksum", 64'(checksum), 64'd0);
    chk("rst.abort", 64'(load_abort), 64'd0);
    chk("rst.tail", 64'(fpga_tail), 64'd0);
    chk("rst.strobe", 64'(word_strobe), 64'd0);
    reset = 1'b1;
    tick(2);

    // Table-driven loads: prog_clk period 8 clk.
    for (int r = 0; r < 7; r++) begin
      start_load();
      send(tbl[r].data, tbl[r].nbits, 4, 4);
      drop_load();
      chk($sformatf("tbl%0d.cfg", r), config_bits, tbl[r].e_cfg);
      chk($sformatf("tbl%0d.valid", r), 64'(config_valid), 64'(tbl[r].e_valid));
      chk($sformatf("tbl%0d.count", r), 64'(bit_count), 64'(tbl[r].e_count));
      chk($sformatf("tbl%0d.cksum", r), 64'(checksum), 64'(tbl[r].e_cksum));
      chk($sformatf("tbl%0d.abort", r), 64'(load_abort), 64'(tbl[r].e_abort));
      check_model($sformatf("tbl%0d.model", r));
    end

    // Readback: after a full load, 64 more edges return the value MSB-first.
    v = 64'hDEADBEEF_01234567;
    start_load();
    send(v, 64, 4, 4);
    chk("rb.cfg_loaded", config_bits, v);
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("rb.tail%0d", k), 64'(fpga_tail), 64'(v[63 - k]));
      pulse(1'b0, 4, 4);
    end
    chk("rb.cfg_kept", config_bits, v);
    chk("rb.count", 64'(bit_count), 64'd128);
    chk("rb.cksum", 64'(checksum), 64'hDFD10456);
    check_model("rb.model");
    drop_load();
    chk("rb.abort", 64'(load_abort), 64'd0);

    // Edges with prog_en low must not touch the chain or counters.
    start_load();
    send(64'h80000000_00000001, 64, 4, 4);
    drop_load();
    for (int k = 0; k < 10; k++) pulse(1'($urandom_range(0, 1)), 4, 4);
    chk("idle.tail", 64'(fpga_tail), 64'd1);
    chk("idle.count", 64'(bit_count), 64'd64);
    chk("idle.cfg", config_bits, 64'h80000000_00000001);
    check_model("idle.model");

    // Reset in the middle of a load, then a clean load at minimum phases.
    start_load();
    send(64'h12345678_9ABCDEF0, 20, 4, 4);
    reset = 1'b0;
    tick(1);
    chk("mrst.cfg", config_bits, 64'd0);
    chk("mrst.valid", 64'(config_valid), 64'd0);
    chk("mrst.count", 64'(bit_count), 64'd0);
    chk("mrst.cksum", 64'(checksum), 64'd0);
    chk("mrst.tail", 64'(fpga_tail), 64'd0);
    chk("mrst.abort", 64'(load_abort), 64'd0);
    prog_en = 1'b0;
    reset = 1'b1;
    m_reset();
    tick(2);
    start_load();
    send(64'h0F1E2D3C_4B5A6978, 64, SS + 1, SS + 1);
    drop_load();
    chk("minph.cfg", config_bits, 64'h0F1E2D3C_4B5A6978);
    chk("minph.count", 64'(bit_count), 64'd64);
    chk("minph.cksum", 64'(checksum), 64'h5A7896B4);
    chk("minph.valid", 64'(config_valid), 64'd1);
    check_model("minph.model");

    // prog_en falls in the very cycle of the final shift event.
    v = 64'h13579BDF_2468ACE0;
    start_load();
    send(v, 63, 4, 4);
    fpga_head = v[0]; prog_clk = 1'b1; tick(2);
    prog_en = 1'b0; tick(2);
    prog_clk = 1'b0; tick(4);
    m_bit(v[0]); m_drop();
    chk("lastdrop.cfg", config_bits, v);
    chk("lastdrop.abort", 64'(load_abort), 64'd0);
    chk("lastdrop.count", 64'(bit_count), 64'd64);
    chk("lastdrop.cksum", 64'(checksum), 64'h37C048BF);
    check_model("lastdrop.model");

    // prog_en rises in the very cycle of a shift event: that edge is dropped.
    fpga_head = 1'b1; prog_clk = 1'b1; tick(2);
    prog_en = 1'b1; tick(2);
    prog_clk = 1'b0; tick(4);
    m_start();
    chk("risesh.count", 64'(bit_count), 64'd0);
    send(64'hFEDCBA98_76543210, 64, 4, 4);
    drop_load();
    chk("risesh.cfg", config_bits, 64'hFEDCBA98_76543210);
    chk("risesh.cksum", 64'(checksum), 64'h7530ECA8);
    check_model("risesh.model");

    // Random loads of random length and phase, checked against the model.
    for (int t = 0; t < 25; t++) begin
      int n;
      n = $urandom_range(0, 80);
      start_load();
      for (int i = 0; i < n; i++)
        pulse(1'($urandom_range(0, 1)), $urandom_range(SS + 1, 5), $urandom_range(SS + 1, 5));
      check_model($sformatf("rnd%0d.mid", t));
      drop_load();
      for (int i = 0; i < int'($urandom_range(0, 3)); i++)
        pulse(1'($urandom_range(0, 1)), 4, 4);
      check_model($sformatf("rnd%0d.end", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
